// File: rtl/sevenseg_reader.sv
// sevenseg_reader: watches a multiplexed 7-segment bus and debounces each digit.
// It decodes the stable patterns back to 4-bit codes and hands out complete frames
// over a valid/ready handshake.
module sevenseg_reader #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_in,
    input  logic [NDIG-1:0]        dig_en,
    input  logic                   sample,
    output logic [4*NDIG-1:0]      digits_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic                   sel_err,
    input  logic                   clr_err
);

    localparam int unsigned   CW     = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CntMax = CW'(STABLE);
    localparam logic [CW-1:0] CntOne = CW'(1);

    // Exact-match decode; blank shows as F, anything unrecognised as E.
    function automatic logic [3:0] decode(input logic [6:0] p);
        logic [3:0] c;
        case (p)
            7'h7E:   c = 4'h0;
            7'h30:   c = 4'h1;
            7'h6D:   c = 4'h2;
            7'h79:   c = 4'h3;
            7'h33:   c = 4'h4;
            7'h5B:   c = 4'h5;
            7'h5F:   c = 4'h6;
            7'h70:   c = 4'h7;
            7'h7F:   c = 4'h8;
            7'h7B:   c = 4'h9;
            7'h00:   c = 4'hF;
            default: c = 4'hE;
        endcase
        return c;
    endfunction

    logic [NDIG-1:0][3:0]    cand_q, cand_d;
    logic [NDIG-1:0][3:0]    comm_q, comm_d;
    logic [NDIG-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NDIG-1:0]         seen_q, seen_d;
    logic [4*NDIG-1:0]       digits_q, digits_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sel_err_q, sel_err_d;

    logic [3:0] code;
    logic       one_hot;
    logic       multi_hot;
    logic       changed;
    logic       frame_done;

    // Decode the bus and classify the digit select.
    always_comb begin
        code      = decode(seg_in);
        one_hot   = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
        multi_hot = (dig_en != '0) && !one_hot;
    end

    // Debounce, commit, frame assembly, handshake and sticky error flags.
    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        comm_d     = comm_q;
        seen_d     = seen_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        changed    = 1'b0;
        // Clear first so that a set on the same edge still wins.
        overrun_d  = clr_err ? 1'b0 : overrun_q;
        sel_err_d  = clr_err ? 1'b0 : sel_err_q;

        if (sample && multi_hot) begin
            sel_err_d = 1'b1;
        end

        if (sample && one_hot) begin
            for (int i = 0; i < NDIG; i++) begin
                if (dig_en[i]) begin
                    changed = (code != cand_q[i]);
                    if (!changed) begin
                        if (cnt_q[i] < CntMax) begin
                            cnt_d[i] = cnt_q[i] + CntOne;
                        end
                    end else begin
                        cand_d[i] = code;
                        cnt_d[i]  = CntOne;
                    end
                    // Commit once per stable run; a change restarts the run.
                    if ((cnt_d[i] == CntMax) && (changed || (cnt_q[i] < CntMax))) begin
                        comm_d[i] = cand_d[i];
                        seen_d[i] = 1'b1;
                    end
                end
            end
        end

        frame_done = &seen_d;
        if (frame_done) begin
            seen_d = '0;
            if (!valid_q || out_ready) begin
                digits_d = comm_d;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset to the blank display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q    <= {NDIG{4'hF}};
            cnt_q     <= '0;
            comm_q    <= {NDIG{4'hF}};
            seen_q    <= '0;
            digits_q  <= '1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            comm_q    <= comm_d;
            seen_q    <= seen_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign digits_out = digits_q;
    assign out_valid  = valid_q;
    assign overrun    = overrun_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Scoreboard bench for sevenseg_reader: a run-length reference model pushes expected
// frames; a negedge monitor checks flags every cycle and pops frames on transfer.
module tb_sevenseg_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;
    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_en;
    logic              sample;
    logic [4*NDIG-1:0] digits_out;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              sel_err;
    logic              clr_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: current run per digit, last committed code, frame bookkeeping.
    logic [3:0]  run_code [NDIG];
    int          run_len  [NDIG];
    logic [3:0]  m_comm   [NDIG];
    bit          m_seen   [NDIG];
    bit          m_valid, m_ovr, m_sel;
    logic [15:0] exp_q [$];

    sevenseg_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_en     (dig_en),
        .sample     (sample),
        .digits_out (digits_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .sel_err    (sel_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (PAT[k] == p) return 4'(k);
        end
        return 4'hE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            run_code[i] = 4'hF;
            run_len[i]  = 0;
            m_comm[i]   = 4'hF;
            m_seen[i]   = 1'b0;
        end
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_sel   = 1'b0;
        exp_q.delete();
    endtask

    // Called right after an active edge, while the inputs sampled there are still applied.
    task automatic model_edge();
        bit          done;
        int          idx;
        logic [3:0]  c;
        logic [15:0] fr;
        done = 1'b0;
        idx  = 0;
        if (clr_err) begin
            m_ovr = 1'b0;
            m_sel = 1'b0;
        end
        if (sample && $countones(dig_en) > 1) begin
            m_sel = 1'b1;
        end else if (sample && $countones(dig_en) == 1) begin
            for (int i = 0; i < NDIG; i++) if (dig_en[i]) idx = i;
            c = ref_decode(seg_in);
            if (c == run_code[idx]) begin
                run_len[idx]++;
            end else begin
                run_code[idx] = c;
                run_len[idx]  = 1;
            end
            if (run_len[idx] == STABLE) begin
                m_comm[idx] = c;
                m_seen[idx] = 1'b1;
            end
            done = 1'b1;
            for (int i = 0; i < NDIG; i++) if (!m_seen[i]) done = 1'b0;
        end
        if (done) begin
            for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
            if (!m_valid || out_ready) begin
                for (int i = 0; i < NDIG; i++) fr[4*i +: 4] = m_comm[i];
                exp_q.push_back(fr);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: flags every cycle; the presented frame against the scoreboard head.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("sel_err", 32'(sel_err), 32'(m_sel));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame at %0t: got %0h with out_valid=1, expected no frame",
                         $time, digits_out);
            end else begin
                chk("frame", 32'(digits_out), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic s, input logic [NDIG-1:0] en, input logic [6:0] seg,
                         input logic rdy, input logic clr);
        sample    = s;
        dig_en    = en;
        seg_in    = seg;
        out_ready = rdy;
        clr_err   = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rounds(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                          input logic [6:0] p3, input int n, input logic rdy);
        logic [6:0] p [NDIG];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < NDIG; k++) drive(1'b1, 4'(1) << k, p[k], rdy, 1'b0);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        sample = 1'b0; dig_en = '0; out_ready = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_digits", 32'(digits_out), 32'hFFFF);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0]      ep [NDIG];
        logic [NDIG-1:0] en;
        int              k, r, sel;

        rst = 1'b1; sample = 1'b0; dig_en = '0; seg_in = '0; out_ready = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Partial frame, then reset mid-operation; 11 samples must not complete a frame.
        rounds(7'h5B, 7'h5F, 7'h70, 7'h7F, 2, 1'b0);
        do_reset();
        rounds(7'h30, 7'h6D, 7'h79, 7'h33, 2, 1'b0);
        for (int j = 0; j < 3; j++) drive(1'b1, 4'(1) << j, (j == 0) ? 7'h30 :
                                          (j == 1) ? 7'h6D : 7'h79, 1'b0, 1'b0);
        chk("no_frame_11", 32'(out_valid), 32'h0);
        drive(1'b1, 4'b1000, 7'h33, 1'b0, 1'b0);
        chk("clean_valid", 32'(out_valid), 32'h1);
        chk("clean_frame", 32'(digits_out), 32'h4321);
        drive(1'b0, '0, 7'h00, 1'b1, 1'b0);

        // Glitch on digit 2 delays the frame until the new pattern is stable.
        do_reset();
        rounds(7'h30, 7'h6D, 7'h79, 7'h33, 1, 1'b0);
        rounds(7'h30, 7'h6D, 7'h7F, 7'h33, 2, 1'b0);
        chk("glitch_no_frame", 32'(out_valid), 32'h0);
        rounds(7'h30, 7'h6D, 7'h7F, 7'h33, 1, 1'b0);
        chk("glitch_valid", 32'(out_valid), 32'h1);
        chk("glitch_frame", 32'(digits_out), 32'h4821);
        drive(1'b0, '0, 7'h00, 1'b1, 1'b0);

        // Decode edges on digit 0: blank, invalid, nine.
        rounds(7'h00, 7'h5B, 7'h5F, 7'h70, 3, 1'b1);
        chk("dec_blank", 32'(digits_out), 32'h765F);
        rounds(7'h01, 7'h7E, 7'h30, 7'h6D, 3, 1'b1);
        chk("dec_invalid", 32'(digits_out), 32'h210E);
        rounds(7'h7B, 7'h5B, 7'h5F, 7'h70, 3, 1'b1);
        chk("dec_nine", 32'(digits_out), 32'h7659);
        drive(1'b0, '0, 7'h00, 1'b1, 1'b0);

        // Backpressure: second frame dropped, clear, then complete on a transfer edge.
        rounds(7'h30, 7'h6D, 7'h79, 7'h33, 3, 1'b0);
        rounds(7'h7E, 7'h7E, 7'h7E, 7'h7E, 3, 1'b0);
        chk("bp_overrun", 32'(overrun), 32'h1);
        chk("bp_retained", 32'(digits_out), 32'h4321);
        drive(1'b0, '0, 7'h00, 1'b0, 1'b1);
        chk("bp_cleared", 32'(overrun), 32'h0);
        rounds(7'h5B, 7'h5B, 7'h5B, 7'h5B, 2, 1'b0);
        for (int j = 0; j < 3; j++) drive(1'b1, 4'(1) << j, 7'h5B, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 7'h5B, 1'b1, 1'b0);
        chk("bp_same_edge_valid", 32'(out_valid), 32'h1);
        chk("bp_same_edge_frame", 32'(digits_out), 32'h5555);
        drive(1'b0, '0, 7'h00, 1'b1, 1'b0);
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Select errors: multi-hot flags, zero is silently ignored.
        drive(1'b1, 4'b0110, 7'h30, 1'b0, 1'b0);
        chk("sel_multi", 32'(sel_err), 32'h1);
        drive(1'b1, 4'b0000, 7'h30, 1'b0, 1'b0);
        chk("sel_zero_valid", 32'(out_valid), 32'h0);
        drive(1'b0, '0, 7'h00, 1'b0, 1'b1);
        chk("sel_cleared", 32'(sel_err), 32'h0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            if (c % 20 == 0) begin
                for (int d = 0; d < NDIG; d++) begin
                    r = $urandom_range(0, 11);
                    ep[d] = (r < 10) ? PAT[r] : ((r == 10) ? 7'h00 : 7'($urandom));
                end
            end
            k   = $urandom_range(0, NDIG - 1);
            sel = $urandom_range(0, 19);
            en  = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'($urandom) : 4'(1) << k;
            drive($urandom_range(0, 9) < 8, en,
                  ($urandom_range(0, 19) == 0) ? 7'($urandom) : ep[k],
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            if (c == 700) do_reset();
        end

        drive(1'b0, '0, 7'h00, 1'b1, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(m_valid ? 1 : 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
